// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MIPS pipeline constants, fetch state encoding and helpers
package mips_pipe_pkg;

  // pc_src encodings driven by the ID-stage branch resolver
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Instruction word used for bubbles and flushed slots (sll $0,$0,0)
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  // Instruction fetches are word aligned; low address bits are discarded
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// rtl/fetch_pc_sel.sv - combinational next-PC select: sequential, branch or jump target
module fetch_pc_sel
  import mips_pipe_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic        redirect
);

  // Decode pc_src; the unused encoding 11 falls through to sequential
  always_comb begin
    pc_plus4 = pc + 32'd4;
    target   = pc_plus4;
    redirect = 1'b0;
    case (pc_src)
      PC_BRANCH: begin
        target   = align_word(branch_target);
        redirect = 1'b1;
      end
      PC_JUMP: begin
        target   = align_word(jump_target);
        redirect = 1'b1;
      end
      default: begin
        target   = pc_plus4;
        redirect = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - IF stage: PC, imem req/ack fetch, IF/ID register, redirects (FETCH_PERF_EN adds counters)
module fetch_redirect_unit
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_src,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_killed
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         kill_pending;
  logic [31:0]  kill_target;
  logic [31:0]  hold_pc4;
  logic [31:0]  hold_instr;

  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redirect;

  logic         fetch_ack;
  logic         drop_ack;
  logic         drop_hold;
  logic         load_fetch;
  logic         load_hold;

  fetch_pc_sel u_pc_sel (
    .pc            (pc),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .pc_plus4      (pc_plus4),
    .target        (target),
    .redirect      (redirect)
  );

  assign imem_addr = pc;

  // An ack is only meaningful while a request is outstanding; after reset req=0 so late acks vanish
  assign fetch_ack  = (state == S_FETCH) && imem_ack;
  assign drop_ack   = fetch_ack && (redirect || kill_pending || flush);
  assign drop_hold  = (state == S_HOLD) && redirect;
  assign load_fetch = fetch_ack && !drop_ack && !stall;
  assign load_hold  = (state == S_HOLD) && !redirect && !stall && !flush;

  // Fetch FSM: PC sequencing, pending-kill tracking for in-flight redirects, hold buffer capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      imem_req     <= 1'b0;
      pc           <= RESET_PC;
      kill_pending <= 1'b0;
      kill_target  <= 32'h0;
      hold_pc4     <= 32'h0;
      hold_instr   <= NOP_INSTR;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
          if (redirect) pc <= target;
        end
        S_FETCH: begin
          if (imem_ack) begin
            kill_pending <= 1'b0;
            if (redirect) begin
              pc <= target;
            end else if (kill_pending) begin
              pc <= kill_target;
            end else begin
              pc <= pc_plus4;
              if (stall && !flush) begin
                hold_pc4   <= pc_plus4;
                hold_instr <= imem_rdata;
                state      <= S_HOLD;
                imem_req   <= 1'b0;
              end
            end
          end else if (redirect) begin
            // Address must stay stable until the ack, so remember where to go afterwards
            kill_pending <= 1'b1;
            kill_target  <= target;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc       <= target;
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end else if (!stall && !flush) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: flush beats stall beats a new load; otherwise a bubble enters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc4   <= 32'h0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (stall) begin
      ifid_valid <= ifid_valid;
    end else if (load_fetch) begin
      ifid_pc4   <= pc_plus4;
      ifid_instr <= imem_rdata;
      ifid_valid <= 1'b1;
    end else if (load_hold) begin
      ifid_pc4   <= hold_pc4;
      ifid_instr <= hold_instr;
      ifid_valid <= 1'b1;
    end else begin
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  // Event counters: accepted redirects and fetched words thrown away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirects <= 32'h0;
      perf_killed    <= 32'h0;
    end else begin
      if (redirect) perf_redirects <= perf_redirects + 32'd1;
      if (drop_ack || drop_hold) perf_killed <= perf_killed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - self-checking bench for fetch_redirect_unit (FETCH_PERF_EN checks counters)
module tb_fetch_redirect_unit;

  localparam logic [31:0] NOP  = 32'hFC00_0000;
  localparam logic [31:0] WKEY = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        req2;
  logic [31:0] addr2;
  logic [31:0] pc4_2;
  logic [31:0] instr2;
  logic        valid2;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_killed;
  logic [31:0] pr2;
  logic [31:0] pk2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: word content is a fixed function of its address
  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ WKEY;
  endfunction
  assign imem_rdata = w(imem_addr);

  fetch_redirect_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
`ifdef FETCH_PERF_EN
    .perf_redirects (perf_redirects),
    .perf_killed    (perf_killed),
`endif
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_src        (pc_src),
    .flush         (flush),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_pc4      (ifid_pc4),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid)
  );

  fetch_redirect_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut2 (
`ifdef FETCH_PERF_EN
    .perf_redirects (pr2),
    .perf_killed    (pk2),
`endif
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_src        (pc_src),
    .flush         (flush),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .stall         (stall),
    .imem_req      (req2),
    .imem_addr     (addr2),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_pc4      (pc4_2),
    .ifid_instr    (instr2),
    .ifid_valid    (valid2)
  );

  typedef struct {
    logic [1:0]  src;
    logic        fl;
    logic        st;
    logic        ack;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        cpc4;
  } vec_t;

  vec_t vec[19];
  vec_t exp_q[$];
  vec_t e;

  function automatic vec_t mk(input logic [1:0] src, input logic fl, input logic st, input logic ack,
                              input logic [31:0] bt, input logic [31:0] jt, input logic req,
                              input logic [31:0] addr, input logic valid, input logic [31:0] pc4,
                              input logic [31:0] instr, input logic cpc4);
    vec_t v;
    v.src = src; v.fl = fl; v.st = st; v.ack = ack; v.bt = bt; v.jt = jt;
    v.req = req; v.addr = addr; v.valid = valid; v.pc4 = pc4; v.instr = instr; v.cpc4 = cpc4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // src fl st ack  bt     jt       | req addr      valid pc4       instr      chk_pc4
    vec[0]  = mk(2'b00,0,0,0, 32'h0,   32'h0,   1, 32'h0,   0, 32'h0,   NOP,        1);
    vec[1]  = mk(2'b00,0,0,1, 32'h0,   32'h0,   1, 32'h4,   1, 32'h4,   w(32'h0),   1);
    vec[2]  = mk(2'b00,0,0,1, 32'h0,   32'h0,   1, 32'h8,   1, 32'h8,   w(32'h4),   1);
    vec[3]  = mk(2'b00,0,1,1, 32'h0,   32'h0,   0, 32'hC,   1, 32'h8,   w(32'h4),   1);
    vec[4]  = mk(2'b00,0,1,0, 32'h0,   32'h0,   0, 32'hC,   1, 32'h8,   w(32'h4),   1);
    vec[5]  = mk(2'b00,0,0,0, 32'h0,   32'h0,   1, 32'hC,   1, 32'hC,   w(32'h8),   1);
    vec[6]  = mk(2'b00,0,0,1, 32'h0,   32'h0,   1, 32'h10,  1, 32'h10,  w(32'hC),   1);
    vec[7]  = mk(2'b01,1,0,1, 32'h40,  32'h0,   1, 32'h40,  0, 32'h0,   NOP,        0);
    vec[8]  = mk(2'b00,0,0,1, 32'h0,   32'h0,   1, 32'h44,  1, 32'h44,  w(32'h40),  1);
    vec[9]  = mk(2'b10,0,0,0, 32'h0,   32'h100, 1, 32'h44,  0, 32'h0,   NOP,        0);
    vec[10] = mk(2'b00,0,0,0, 32'h0,   32'h0,   1, 32'h44,  0, 32'h0,   NOP,        0);
    vec[11] = mk(2'b00,0,0,0, 32'h0,   32'h0,   1, 32'h44,  0, 32'h0,   NOP,        0);
    vec[12] = mk(2'b00,0,0,1, 32'h0,   32'h0,   1, 32'h100, 0, 32'h0,   NOP,        0);
    vec[13] = mk(2'b11,0,0,1, 32'h200, 32'h300, 1, 32'h104, 1, 32'h104, w(32'h100), 1);
    vec[14] = mk(2'b00,1,1,0, 32'h0,   32'h0,   1, 32'h104, 0, 32'h0,   NOP,        0);
    vec[15] = mk(2'b00,0,0,1, 32'h0,   32'h0,   1, 32'h108, 1, 32'h108, w(32'h104), 1);
    vec[16] = mk(2'b00,0,1,1, 32'h0,   32'h0,   0, 32'h10C, 1, 32'h108, w(32'h104), 1);
    vec[17] = mk(2'b01,0,1,0, 32'h203, 32'h0,   1, 32'h200, 1, 32'h108, w(32'h104), 1);
    vec[18] = mk(2'b00,0,0,1, 32'h0,   32'h0,   1, 32'h204, 1, 32'h204, w(32'h200), 1);

    rst_n = 1'b0; pc_src = 2'b00; flush = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req", {31'h0, imem_req}, 32'h0);
    chk("reset addr", imem_addr, 32'h0);
    chk("reset valid", {31'h0, ifid_valid}, 32'h0);
    chk("reset pc4", ifid_pc4, 32'h0);
    chk("reset instr", ifid_instr, NOP);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      pc_src = vec[i].src; flush = vec[i].fl; stall = vec[i].st; imem_ack = vec[i].ack;
      branch_target = vec[i].bt; jump_target = vec[i].jt;
      exp_q.push_back(vec[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d req", i), {31'h0, imem_req}, {31'h0, e.req});
      chk($sformatf("v%0d addr", i), imem_addr, e.addr);
      chk($sformatf("v%0d valid", i), {31'h0, ifid_valid}, {31'h0, e.valid});
      chk($sformatf("v%0d instr", i), ifid_instr, e.instr);
      if (e.cpc4) chk($sformatf("v%0d pc4", i), ifid_pc4, e.pc4);
      if (i == 0) chk("wrap first addr", addr2, 32'hFFFF_FFFC);
      if (i == 1) chk("wrap second addr", addr2, 32'h0000_0000);
    end

`ifdef FETCH_PERF_EN
    chk("perf_redirects", perf_redirects, 32'd3);
    chk("perf_killed", perf_killed, 32'd3);
`endif

    // Fetch of 0x204 left waiting, then reset asserted mid-cycle
    @(negedge clk);
    pc_src = 2'b00; flush = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst req", {31'h0, imem_req}, 32'h0);
    chk("midrst addr", imem_addr, 32'h0);
    chk("midrst valid", {31'h0, ifid_valid}, 32'h0);
    chk("midrst pc4", ifid_pc4, 32'h0);
    chk("midrst instr", ifid_instr, NOP);
`ifdef FETCH_PERF_EN
    chk("midrst perf_killed", perf_killed, 32'h0);
`endif
    // Late ack during and right after reset must be ignored
    @(negedge clk);
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("late ack req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("restart addr", imem_addr, 32'h0);
    chk("restart req", {31'h0, imem_req}, 32'h1);
    chk("restart valid", {31'h0, ifid_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk("restart pc4", ifid_pc4, 32'h4);
    chk("restart instr", ifid_instr, w(32'h0));
    chk("restart valid2", {31'h0, ifid_valid}, 32'h1);
    @(negedge clk);
    imem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
